// File: rtl/arch_maptable_pkg.sv
// Shared types and constants for the architectural (retirement) map table.
package arch_maptable_pkg;

  localparam int SUPERSCALAR_WAYS = 3;
  localparam int N_ARCH_REG       = 32;
  localparam int N_ARCH_REG_BITS  = 5;
  localparam int N_PHYS_REG       = 64;
  localparam int N_PHYS_REG_BITS  = 6;
  localparam logic [N_ARCH_REG_BITS-1:0] ZERO_REG = 5'd0;

  typedef logic [N_ARCH_REG_BITS-1:0] arch_idx_t;
  typedef logic [N_PHYS_REG_BITS-1:0] phys_idx_t;
  typedef phys_idx_t [N_ARCH_REG-1:0] map_t;

  typedef struct packed {
    map_t                  map;
    logic [N_ARCH_REG-1:0] done;
  } MAPTABLE_PACKET;

  typedef struct packed {
    logic      enable;
    arch_idx_t ar_idx;
    phys_idx_t pr_idx;
  } RETIRE_ARCHMAP_PACKET;

  typedef struct packed {
    logic      valid;
    phys_idx_t pr_idx;
  } ARCHMAP_FREE_PACKET;

  // A retire lane changes state only when enabled and not targeting r0.
  function automatic logic lane_active(input RETIRE_ARCHMAP_PACKET pkt);
    return pkt.enable && (pkt.ar_idx != ZERO_REG);
  endfunction

endpackage

// File: rtl/arch_maptable_told_resolve.sv
// Combinational intra-bundle forwarding: per-lane superseded register (told)
// and the map after applying the whole retire bundle in lane order.
module archmap_told_resolve
  import arch_maptable_pkg::*;
(
  input  map_t                                        map_i,
  input  RETIRE_ARCHMAP_PACKET [SUPERSCALAR_WAYS-1:0] retire_in,
  output logic                 [SUPERSCALAR_WAYS-1:0] act_o,
  output phys_idx_t            [SUPERSCALAR_WAYS-1:0] told_o,
  output map_t                                        map_next_o
);

  // Resolve told from older same-register lanes, then apply lanes oldest first.
  always_comb begin
    act_o      = '0;
    told_o     = '0;
    map_next_o = map_i;
    for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
      act_o[i] = lane_active(retire_in[i]);
    end
    for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
      told_o[i] = map_i[retire_in[i].ar_idx];
      // Ascending j: the youngest older lane writing the same register wins.
      for (int j = 0; j < SUPERSCALAR_WAYS; j++) begin
        told_o[i] = ((j < i) && act_o[j] &&
                     (retire_in[j].ar_idx == retire_in[i].ar_idx))
                    ? retire_in[j].pr_idx : told_o[i];
      end
    end
    for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
      map_next_o[retire_in[i].ar_idx] = act_o[i] ? retire_in[i].pr_idx
                                                 : map_next_o[retire_in[i].ar_idx];
    end
  end

endmodule

// File: rtl/arch_maptable.sv
// Architectural map table: committed arch->phys mapping, Told release toward
// the free list, and a zero-latency recovery map for branch mispredicts.
module arch_maptable
  import arch_maptable_pkg::*;
(
  input  logic                                        clock,
  input  logic                                        reset,
  input  RETIRE_ARCHMAP_PACKET [SUPERSCALAR_WAYS-1:0] retire_in,
  output MAPTABLE_PACKET                              recovery_maptable,
  output MAPTABLE_PACKET                              arch_map_out,
  output ARCHMAP_FREE_PACKET   [SUPERSCALAR_WAYS-1:0] freed_out
);

  map_t                                      map_q;
  map_t                                      map_d;
  ARCHMAP_FREE_PACKET [SUPERSCALAR_WAYS-1:0] freed_q;
  ARCHMAP_FREE_PACKET [SUPERSCALAR_WAYS-1:0] freed_d;

  logic      [SUPERSCALAR_WAYS-1:0] act_s;
  phys_idx_t [SUPERSCALAR_WAYS-1:0] told_s;
  map_t                             map_next_s;

  archmap_told_resolve u_told_resolve (
    .map_i      (map_q),
    .retire_in  (retire_in),
    .act_o      (act_s),
    .told_o     (told_s),
    .map_next_o (map_next_s)
  );

  // Next-state: reset restores the identity map and drops the bundle.
  always_comb begin
    map_d   = map_next_s;
    freed_d = '0;
    if (reset) begin
      for (int i = 0; i < N_ARCH_REG; i++) begin
        map_d[i] = N_PHYS_REG_BITS'(i);
      end
      freed_d = '0;
    end else begin
      for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
        freed_d[i].valid  = act_s[i];
        freed_d[i].pr_idx = told_s[i];
      end
    end
  end

  // State registers: committed map and lane-aligned freed Told.
  always_ff @(posedge clock) begin
    map_q   <= map_d;
    freed_q <= freed_d;
  end

  // Recovery map bypasses the register so this cycle's retirements are included.
  always_comb begin
    recovery_maptable.map  = map_next_s;
    recovery_maptable.done = {N_ARCH_REG{1'b1}};
    arch_map_out.map       = map_q;
    arch_map_out.done      = {N_ARCH_REG{1'b1}};
    freed_out              = freed_q;
  end

endmodule
